// File: rtl/pc_npc.sv
// Program counter and next-PC unit for the single-cycle MIPS datapath.
// Selects the successor fetch address, checks that it is aligned and inside
// the instruction-memory window, and traps illegal targets into a sticky halt.
module pc_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  npc_op,
    input  logic        cmp_eq,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halt,
    output logic [1:0]  fault,
    output logic [31:0] retire_cnt
);

    localparam logic [1:0] OP_SEQ = 2'b00;
    localparam logic [1:0] OP_BEQ = 2'b01;
    localparam logic [1:0] OP_J   = 2'b10;
    localparam logic [1:0] OP_JR  = 2'b11;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Last legal byte address of the fetch window.
    localparam logic [31:0] WIN_HI = RESET_PC + 32'(IM_BYTES) - 32'd1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  fault_q, fault_d;
    logic [0:0]  state_q, state_d;

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] nxt;
    logic        misaligned;
    logic        out_of_window;

    assign seq_pc     = pc_q + 32'd4;
    assign br_off     = {{14{imm16[15]}}, imm16, 2'b00};
    assign pc         = pc_q;
    assign pc_plus4   = seq_pc;
    assign halt       = (state_q == ST_HALT);
    assign fault      = fault_q;
    assign retire_cnt = cnt_q;

    // Successor selection; each field is only looked at by the op that owns it,
    // so unused instruction fields cannot leak into the PC.
    always_comb begin
        nxt = seq_pc;
        case (npc_op)
            OP_SEQ:  nxt = seq_pc;
            OP_BEQ:  nxt = cmp_eq ? (seq_pc + br_off) : seq_pc;
            OP_J:    nxt = {pc_q[31:28], imm26, 2'b00};
            OP_JR:   nxt = rs_val;
            default: nxt = seq_pc;
        endcase
    end

    // Legality of the candidate target; alignment is reported ahead of range.
    always_comb begin
        misaligned    = (nxt[1:0] != 2'b00);
        out_of_window = (nxt < RESET_PC) || (nxt > WIN_HI);
    end

    // RUN/HALT control: advance on legal targets, trap on illegal ones,
    // and freeze everything once halted. Stalls skip the legality check.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        state_d = state_q;
        if (state_q == ST_RUN && en) begin
            if (misaligned) begin
                fault_d = FAULT_ALIGN;
                state_d = ST_HALT;
            end else if (out_of_window) begin
                fault_d = FAULT_RANGE;
                state_d = ST_HALT;
            end else begin
                pc_d  = nxt;
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // State registers with synchronous reset back to the window base.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
            fault_q <= FAULT_NONE;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_pc_npc.sv
// Self-checking bench for pc_npc: directed steps from the test plan followed
// by a randomized run, all checked against an arithmetic reference model.
module tb_pc_npc;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam longint      WIN  = 4096;

    logic        clk = 1'b0;
    logic        reset, en, cmp_eq;
    logic [1:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic [31:0] pc, pc_plus4, retire_cnt;
    logic        halt;
    logic [1:0]  fault;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_halt;
    logic [1:0]  m_fault;

    pc_npc #(.RESET_PC(BASE), .IM_BYTES(4096)) dut (
        .clk(clk), .reset(reset), .en(en), .npc_op(npc_op), .cmp_eq(cmp_eq),
        .imm16(imm16), .imm26(imm26), .rs_val(rs_val),
        .pc(pc), .pc_plus4(pc_plus4), .halt(halt), .fault(fault),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Model: the target is computed with wide integer arithmetic, then reduced mod 2^32.
    task automatic model_step();
        longint t;
        longint p;
        p = longint'(m_pc);
        case (npc_op)
            2'd0: t = p + 4;
            2'd1: t = cmp_eq ? p + 4 + longint'($signed(imm16)) * 4 : p + 4;
            2'd2: t = (p / 268435456) * 268435456 + longint'(imm26) * 4;
            default: t = longint'(rs_val);
        endcase
        t = t & 64'h0000_0000_FFFF_FFFF;
        if (reset) begin
            m_pc = BASE; m_cnt = 0; m_halt = 0; m_fault = 0;
        end else if (!m_halt && en) begin
            if (t % 4 != 0) begin
                m_halt = 1; m_fault = 2'b01;
            end else if (t < longint'(BASE) || t >= longint'(BASE) + WIN) begin
                m_halt = 1; m_fault = 2'b10;
            end else begin
                m_pc = t[31:0]; m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".halt"}, {31'd0, halt}, {31'd0, m_halt});
        check({tag, ".fault"}, {30'd0, fault}, {30'd0, m_fault});
        check({tag, ".cnt"}, retire_cnt, m_cnt);
    endtask

    // Apply one cycle of inputs, advance model and DUT, then compare.
    task automatic cyc(input string tag, input logic r, input logic e, input logic [1:0] op,
                       input logic c, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs);
        reset = r; en = e; npc_op = op; cmp_eq = c; imm16 = i16; imm26 = i26; rs_val = rs;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1; en = 0; npc_op = 0; cmp_eq = 0; imm16 = 0; imm26 = 0; rs_val = 0;
        m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
        #1;

        // 1. reset and sequential fetch
        cyc("rst0", 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        cyc("rst1", 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        check("rst.pc_const", pc, 32'h3000);
        cyc("seq1", 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        cyc("seq2", 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        cyc("seq3", 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        check("seq.pc_const", pc, 32'h300C);
        check("seq.cnt_const", retire_cnt, 32'd3);
        cyc("seq4", 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);

        // 2. branches, including branch-to-self
        cyc("beq_t", 0, 1, 2'd1, 1, 16'h0003, 26'h0, 32'h0);
        check("beq_t.pc_const", pc, 32'h3020);
        cyc("beq_nt", 0, 1, 2'd1, 0, 16'hFFFC, 26'h0, 32'h0);
        check("beq_nt.pc_const", pc, 32'h3024);
        cyc("beq_bk", 0, 1, 2'd1, 1, 16'hFFFC, 26'h0, 32'h0);
        check("beq_bk.pc_const", pc, 32'h3018);
        cyc("beq_self", 0, 1, 2'd1, 1, 16'hFFFF, 26'h0, 32'h0);
        check("beq_self.pc_const", pc, 32'h3018);

        // 3. jump, jr, stall
        cyc("j", 0, 1, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);
        check("j.pc_const", pc, 32'h3100);
        check("j.pc4_const", pc_plus4, 32'h3104);
        cyc("jr", 0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h3004);
        check("jr.pc_const", pc, 32'h3004);
        for (int i = 0; i < 4; i++)
            cyc("stall", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        check("stall.pc_const", pc, 32'h3004);

        // 4. faults
        cyc("mis", 0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h3006);
        check("mis.fault_const", {30'd0, fault}, 32'd1);
        check("mis.pc_const", pc, 32'h3004);
        cyc("rst_a", 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        cyc("oow_jr", 0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h4000);
        check("oow_jr.fault_const", {30'd0, fault}, 32'd2);
        cyc("rst_b", 1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        cyc("oow_beq", 0, 1, 2'd1, 1, 16'h8000, 26'h0, 32'h0);
        check("oow_beq.fault_const", {30'd0, fault}, 32'd2);

        // 5. halt is sticky; a single reset recovers
        for (int i = 0; i < 5; i++)
            cyc("halted", 0, 1, 2'(i), 1, 16'h0001, 26'h0000C01, BASE + 32'd8);
        cyc("recover", 1, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
        check("recover.halt_const", {31'd0, halt}, 32'd0);
        check("recover.cnt_const", retire_cnt, 32'd0);

        // 6. stall masks an illegal target until en rises
        cyc("mask", 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0);
        check("mask.halt_const", {31'd0, halt}, 32'd0);
        cyc("unmask", 0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h0);
        check("unmask.fault_const", {30'd0, fault}, 32'd2);

        // 7. randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic        r, e, c;
            logic [1:0]  op;
            logic [15:0] i16;
            logic [25:0] i26;
            logic [31:0] rs;
            op  = 2'($urandom_range(0, 3));
            e   = ($urandom_range(0, 9) != 0);
            c   = 1'($urandom);
            i16 = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64)) - 16'd32;
            i26 = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(12'hC00, 12'hFFF));
            rs  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 1023)) * 32'd4;
            r   = (m_halt && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
            cyc("rand", r, e, op, c, i16, i26, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
